id_operand_collector: RTL and testbench
=======================================

Name: id_operand_collector

Overview:
- ID-stage consumer of the bypass bus. It holds one decoded instruction and resolves its two source operands from EXE/MEM/WB forwarding or the register file.
- When a producer's data is not yet available (load-use), it stalls the instruction, then hands the resolved operands to EXE over a valid/ready handshake.
- Resolved operands are latched and kept stable across downstream stalls.

Parameters:
- DW, 32, data width of the register file and operands.
- AW, 5, register address width.
- BYW, 3*(AW+DW+3) = 120, width of the bypass bus.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of the held instruction.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  collector can accept an instruction this cycle.
- src1_addr, src2_addr  in  AW  source register numbers, sampled on accept.
- src1_re, src2_re  in  1  source is actually read, sampled on accept.
- rf_raddr1, rf_raddr2  out  AW  latched source addresses driven to the register file.
- rf_rdata1, rf_rdata2  in  DW  combinational register-file read data.
- by_bus  in  BYW  bypass bus, MSB first. Three slices in the order EXE, MEM, WB. Each slice is {w_addr[AW], w_data[DW], data_valid, stage_valid, w_en}.
- out_valid  out  1  both operands resolved.
- out_ready  in  1  EXE accepts the operands.
- src1_data, src2_data  out  DW  resolved operands.
- stall_cycles  out  32  count of WAIT cycles (optional feature).

Behaviour:
- Reset: state=IDLE. All outputs except in_ready (=1 in IDLE) are 0: out_valid, src*_data, rf_raddr*, stall_cycles. Latched resolve flags are cleared.
- States:
  - IDLE: no instruction held.
  - WAIT: instruction held, at least one operand unresolved.
  - READY: both operands resolved, out_valid=1.
- in_ready = (state==IDLE) || (state==READY && out_ready). It is combinational and never depends on in_valid.
- Accept (in_valid && in_ready):
  - Latch addrs and re flags, clear both resolved flags, next state WAIT.
  - A source with re=0 or addr=0 is marked resolved with data 0 at accept.
- Hit rule for stage s and source n: s.stage_valid && s.w_en && s.w_addr==addr_n && addr_n!=0.
- Resolution, evaluated each WAIT cycle only for unresolved operands:
  - Priority is EXE > MEM > WB > register file. Only the youngest hitting stage is used.
  - Youngest hit has data_valid=1: latch its w_data and mark resolved.
  - Youngest hit has data_valid=0: the operand stays unresolved this cycle. Older stages are not consulted.
  - No hit: latch rf_rdata_n and mark resolved.
- Resolved operands are sticky and are not re-evaluated.
- WAIT to READY on the edge where both operands become resolved.
- Latency: accept at cycle T, earliest out_valid at T+2. Each blocked cycle adds one.
- READY:
  - out_valid=1 and src*_data are held stable until out_ready.
  - On out_ready: go to WAIT if a new instruction is accepted in the same cycle, otherwise IDLE.
- flush:
  - Has priority over accept and resolve. Next state IDLE, out_valid=0, flags cleared.
  - in_ready is still driven per the rule above, but an accept in a flush cycle is discarded.
- Reset asserted mid-operation: immediate return to IDLE. The held instruction is lost and no handshake completes.
- A simultaneous flush and out_ready in READY: the transfer counts as completed (EXE sampled it), then IDLE.

Optional Feature:
- Macro: ID_STALL_CNT_EN.
- Defined:
  - stall_cycles increments by 1 every cycle state==WAIT and not flush.
  - It saturates at 0xFFFFFFFF and is reset to 0 only by reset.
- Undefined: stall_cycles is tied to 0 and no counter logic is generated.

Test Plan:
- No-hit read: RF r3=0x11111111, r4=0x22222222. Accept src1=3, src2=4 with no bypass hits → out_valid at T+2 with src1=0x11111111, src2=0x22222222.
- Priority: EXE and WB both write r5, EXE data 0xAAAA0000 valid, WB data 0x0000BBBB. Source src1=5 → src1_data=0xAAAA0000.
- Load-use stall:
  - EXE hits r6 with data_valid=0 for 1 cycle, then the producer moves to MEM with data_valid=1 and data 0xDEADBEEF.
  - Required: out_valid at T+3, src1=0xDEADBEEF, and stall_cycles=2 with ID_STALL_CNT_EN.
- Zero-register and not-read sources: src1=0 with re=1, and src2 with re=0. An EXE slice writing addr 0 with data 0x5 is present → both operands 0, out_valid at T+2.
- Back-pressure and back-to-back:
  - Hold out_ready=0 for 3 cycles in READY while bypass data for the source changes → src*_data unchanged.
  - Then out_ready=1 with in_valid=1 → new accept in the same cycle, state WAIT.
- Flush and reset: flush in WAIT → IDLE next cycle, out_valid stays 0. Asynchronous reset pulse in READY → out_valid=0 immediately, in_ready=1.

Source files
------------

// File: rtl/id_operand_collector.sv
// id_operand_collector: holds one decoded instruction, resolves both sources from EXE/MEM/WB bypass or RF.
// Optional WAIT-cycle counter on stall_cycles when ID_STALL_CNT_EN is defined.
module id_operand_collector #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int BYW = 3*(AW+DW+3)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [AW-1:0]  src1_addr,
  input  logic [AW-1:0]  src2_addr,
  input  logic           src1_re,
  input  logic           src2_re,
  output logic [AW-1:0]  rf_raddr1,
  output logic [AW-1:0]  rf_raddr2,
  input  logic [DW-1:0]  rf_rdata1,
  input  logic [DW-1:0]  rf_rdata2,
  input  logic [BYW-1:0] by_bus,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  src1_data,
  output logic [DW-1:0]  src2_data,
  output logic [31:0]    stall_cycles
);

  localparam int SW = AW + DW + 3;

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

  state_t        state, state_n;
  logic [AW-1:0] addr1, addr2;
  logic          res1, res2;
  logic [DW-1:0] data1, data2;
  logic          accept, done;
  logic [DW:0]   look1, look2;

  // Youngest hitting stage wins; result is {usable, data}. No hit falls back to RF.
  function automatic logic [DW:0] lookup(
    input logic [AW-1:0]  a,
    input logic [DW-1:0]  rf,
    input logic [BYW-1:0] bus
  );
    logic [SW-1:0] sl;
    logic          hit;
    logic [DW:0]   r;
    r   = {1'b1, rf};
    hit = 1'b0;
    for (int s = 2; s >= 0; s--) begin
      sl = bus[s*SW +: SW];
      if (!hit && sl[1] && sl[0] &&
          sl[SW-1 -: AW] == a && a != '0) begin
        hit = 1'b1;
        r   = {sl[2], sl[DW+2:3]};
      end
    end
    return r;
  endfunction

  assign in_ready  = (state == IDLE) ||
                     (state == READY && out_ready);
  assign out_valid = (state == READY);
  assign rf_raddr1 = addr1;
  assign rf_raddr2 = addr2;
  assign src1_data = data1;
  assign src2_data = data2;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state: accept, resolve completion, handoff; flush overrides all.
  always_comb begin
    look1   = lookup(addr1, rf_rdata1, by_bus);
    look2   = lookup(addr2, rf_rdata2, by_bus);
    accept  = in_valid && in_ready;
    done    = (res1 || look1[DW]) && (res2 || look2[DW]);
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = WAIT;
      WAIT:    if (done) state_n = READY;
      READY:   if (out_ready) state_n = accept ? WAIT : IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  // Operand latches: captured on accept, filled sticky while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr1 <= '0;
      addr2 <= '0;
      res1  <= 1'b0;
      res2  <= 1'b0;
      data1 <= '0;
      data2 <= '0;
    end else if (flush) begin
      res1 <= 1'b0;
      res2 <= 1'b0;
    end else if (accept) begin
      addr1 <= src1_addr;
      addr2 <= src2_addr;
      res1  <= !src1_re || src1_addr == '0;
      res2  <= !src2_re || src2_addr == '0;
      data1 <= '0;
      data2 <= '0;
    end else if (state == WAIT) begin
      if (!res1 && look1[DW]) begin
        res1  <= 1'b1;
        data1 <= look1[DW-1:0];
      end
      if (!res2 && look2[DW]) begin
        res2  <= 1'b1;
        data2 <= look2[DW-1:0];
      end
    end
  end

`ifdef ID_STALL_CNT_EN
  logic [31:0] cnt;

  // Saturating count of non-flushed WAIT cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (state == WAIT && !flush && cnt != '1)
      cnt <= cnt + 32'd1;
  end

  assign stall_cycles = cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_id_operand_collector.sv
// tb_id_operand_collector: directed scenarios plus randomized bypass traffic
// checked against a transaction-level resolution model.
module tb_id_operand_collector;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int SW  = AW + DW + 3;
  localparam int BYW = 3 * SW;

`ifdef ID_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [AW-1:0]  src1_addr, src2_addr;
  logic           src1_re, src2_re;
  logic [AW-1:0]  rf_raddr1, rf_raddr2;
  logic [DW-1:0]  rf_rdata1, rf_rdata2;
  logic [BYW-1:0] by_bus;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  src1_data, src2_data;
  logic [31:0]    stall_cycles;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [DW-1:0] rf_mem [32];
  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  // Pipeline stage view: index 0 = EXE (youngest), 1 = MEM, 2 = WB.
  logic [AW-1:0] st_addr [3];
  logic [DW-1:0] st_data [3];
  logic          st_dv [3];
  logic          st_sv [3];
  logic          st_we [3];

  id_operand_collector dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .src1_addr(src1_addr), .src2_addr(src2_addr),
    .src1_re(src1_re), .src2_re(src2_re),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .by_bus(by_bus),
    .out_valid(out_valid), .out_ready(out_ready),
    .src1_data(src1_data), .src2_data(src2_data),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bus();
    by_bus = '0;
    for (int i = 0; i < 3; i++)
      by_bus[(2-i)*SW +: SW] = {st_addr[i], st_data[i],
                                st_dv[i], st_sv[i], st_we[i]};
  endtask

  task automatic clear_bus();
    for (int i = 0; i < 3; i++) begin
      st_addr[i] = '0; st_data[i] = '0;
      st_dv[i] = 1'b0; st_sv[i] = 1'b0; st_we[i] = 1'b0;
    end
    drive_bus();
  endtask

  task automatic set_stage(input int i, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic dv);
    st_addr[i] = a; st_data[i] = d;
    st_dv[i] = dv; st_sv[i] = 1'b1; st_we[i] = 1'b1;
  endtask

  task automatic accept(input logic [AW-1:0] a1, input logic r1,
                        input logic [AW-1:0] a2, input logic r2);
    in_valid = 1'b1;
    src1_addr = a1; src1_re = r1;
    src2_addr = a2; src2_re = r2;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // Reference: first writing stage from youngest decides; else register file.
  task automatic model_lookup(input logic [AW-1:0] a, output bit ok,
                              output logic [DW-1:0] v);
    ok = 1'b1;
    v  = rf_mem[a];
    for (int i = 0; i < 3; i++) begin
      if (st_sv[i] && st_we[i] && st_addr[i] == a && a != 0) begin
        ok = st_dv[i];
        v  = st_data[i];
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_hs: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    else pass_cnt++;
    total_cnt++;
    if (src1_data !== '0 || src2_data !== '0)
      $display("FAIL reset_data: got %h %h want 0 0", src1_data, src2_data);
    else pass_cnt++;
    total_cnt++;
    if (rf_raddr1 !== '0 || rf_raddr2 !== '0 || stall_cycles !== '0)
      $display("FAIL reset_misc: got %h %h %h want 0", rf_raddr1, rf_raddr2, stall_cycles);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_no_hit();
    rf_mem[3] = 32'h1111_1111;
    rf_mem[4] = 32'h2222_2222;
    clear_bus();
    accept(5'd3, 1'b1, 5'd4, 1'b1);
    total_cnt++;
    if (out_valid !== 1'b0 || rf_raddr1 !== 5'd3 || rf_raddr2 !== 5'd4)
      $display("FAIL nohit_t1: got vld=%b a1=%0d a2=%0d want 0 3 4", out_valid, rf_raddr1, rf_raddr2);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b1 || src1_data !== 32'h1111_1111 || src2_data !== 32'h2222_2222)
      $display("FAIL nohit_t2: got vld=%b %h %h want 1 11111111 22222222", out_valid, src1_data, src2_data);
    else pass_cnt++;
    drain();
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL nohit_drain: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    clear_bus();
    accept(5'd5, 1'b1, 5'd0, 1'b0);
    set_stage(0, 5'd5, 32'hAAAA_0000, 1'b1);
    set_stage(2, 5'd5, 32'h0000_BBBB, 1'b1);
    drive_bus();
    step();
    total_cnt++;
    if (out_valid !== 1'b1 || src1_data !== 32'hAAAA_0000 || src2_data !== '0)
      $display("FAIL priority: got vld=%b %h %h want 1 aaaa0000 0", out_valid, src1_data, src2_data);
    else pass_cnt++;
    clear_bus();
    drain();
  endtask

  task automatic test_load_use();
    pulse_reset();
    clear_bus();
    accept(5'd6, 1'b1, 5'd0, 1'b0);
    set_stage(0, 5'd6, 32'h0BAD_0BAD, 1'b0);
    set_stage(2, 5'd6, 32'h5555_5555, 1'b1);
    drive_bus();
    step();
    total_cnt++;
    if (out_valid !== 1'b0)
      $display("FAIL loaduse_block: got vld=%b want 0", out_valid);
    else pass_cnt++;
    clear_bus();
    set_stage(1, 5'd6, 32'hDEAD_BEEF, 1'b1);
    drive_bus();
    step();
    total_cnt++;
    if (out_valid !== 1'b1 || src1_data !== 32'hDEAD_BEEF)
      $display("FAIL loaduse_data: got vld=%b %h want 1 deadbeef", out_valid, src1_data);
    else pass_cnt++;
    total_cnt++;
    if (stall_cycles !== (CNT_EN ? 32'd2 : 32'd0))
      $display("FAIL loaduse_stall: got %0d want %0d", stall_cycles, CNT_EN ? 2 : 0);
    else pass_cnt++;
    clear_bus();
    drain();
  endtask

  task automatic test_zero_src();
    rf_mem[0] = 32'hBAD0_BAD0;
    rf_mem[9] = 32'h9999_9999;
    clear_bus();
    accept(5'd0, 1'b1, 5'd9, 1'b0);
    set_stage(0, 5'd0, 32'h0000_0005, 1'b1);
    set_stage(1, 5'd9, 32'h1234_5678, 1'b0);
    drive_bus();
    total_cnt++;
    if (out_valid !== 1'b0)
      $display("FAIL zero_t1: got vld=%b want 0", out_valid);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b1 || src1_data !== '0 || src2_data !== '0)
      $display("FAIL zero_t2: got vld=%b %h %h want 1 0 0", out_valid, src1_data, src2_data);
    else pass_cnt++;
    clear_bus();
    drain();
  endtask

  task automatic test_back_to_back();
    rf_mem[7]  = 32'h7777_7777;
    rf_mem[8]  = 32'h8888_8888;
    rf_mem[10] = 32'hA0A0_A0A0;
    clear_bus();
    accept(5'd7, 1'b1, 5'd8, 1'b1);
    step();
    total_cnt++;
    if (out_valid !== 1'b1 || src1_data !== 32'h7777_7777)
      $display("FAIL bp_ready: got vld=%b %h want 1 77777777", out_valid, src1_data);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      set_stage(0, 5'd7, $urandom, 1'b1);
      drive_bus();
      rf_mem[7] = $urandom;
      step();
      total_cnt++;
      if (out_valid !== 1'b1 || src1_data !== 32'h7777_7777 || src2_data !== 32'h8888_8888)
        $display("FAIL bp_hold%0d: got vld=%b %h %h want 1 77777777 88888888", k, out_valid, src1_data, src2_data);
      else pass_cnt++;
    end
    clear_bus();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    src1_addr = 5'd10; src1_re = 1'b1;
    src2_addr = 5'd0;  src2_re = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1)
      $display("FAIL b2b_rdy: got %b want 1", in_ready);
    else pass_cnt++;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || rf_raddr1 !== 5'd10)
      $display("FAIL b2b_wait: got vld=%b rdy=%b a1=%0d want 0 0 10", out_valid, in_ready, rf_raddr1);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b1 || src1_data !== 32'hA0A0_A0A0 || src2_data !== '0)
      $display("FAIL b2b_data: got vld=%b %h %h want 1 a0a0a0a0 0", out_valid, src1_data, src2_data);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_flush();
    clear_bus();
    accept(5'd12, 1'b1, 5'd0, 1'b0);
    set_stage(0, 5'd12, 32'h0, 1'b0);
    drive_bus();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_idle: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    else pass_cnt++;
    set_stage(0, 5'd12, 32'hCAFE_F00D, 1'b1);
    drive_bus();
    step();
    total_cnt++;
    if (out_valid !== 1'b0)
      $display("FAIL flush_stay: got vld=%b want 0", out_valid);
    else pass_cnt++;
    clear_bus();
    in_valid = 1'b1;
    flush    = 1'b1;
    src1_addr = 5'd3; src1_re = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1)
      $display("FAIL flush_acc: got rdy=%b want 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    clear_bus();
    accept(5'd3, 1'b1, 5'd4, 1'b1);
    step();
    total_cnt++;
    if (out_valid !== 1'b1)
      $display("FAIL areset_pre: got vld=%b want 1", out_valid);
    else pass_cnt++;
    #1 reset = 1'b1;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || src1_data !== '0)
      $display("FAIL areset_now: got vld=%b rdy=%b d=%h want 0 1 0", out_valid, in_ready, src1_data);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [AW-1:0] a1, a2;
    logic          r1, r2;
    bit            ok1, ok2, ok, got;
    logic [DW-1:0] v1, v2, v;
    int            waits;
    pulse_reset();
    waits = 0;
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    for (int t = 0; t < 40; t++) begin
      a1 = AW'($urandom_range(0, 7));
      a2 = AW'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 3) != 0);
      r2 = ($urandom_range(0, 3) != 0);
      clear_bus();
      accept(a1, r1, a2, r2);
      ok1 = !r1 || a1 == 0; v1 = '0;
      ok2 = !r2 || a2 == 0; v2 = '0;
      got = 1'b0;
      for (int c = 0; c < 12 && !got; c++) begin
        if (c < 6) begin
          for (int s = 0; s < 3; s++) begin
            st_addr[s] = ($urandom_range(0, 2) == 0) ? a1 :
                         ($urandom_range(0, 1) == 0) ? a2 :
                         AW'($urandom_range(0, 7));
            st_data[s] = $urandom;
            st_dv[s] = ($urandom_range(0, 2) != 0);
            st_sv[s] = ($urandom_range(0, 3) != 0);
            st_we[s] = ($urandom_range(0, 3) != 0);
          end
          drive_bus();
        end else begin
          clear_bus();
        end
        waits++;
        if (!ok1) begin
          model_lookup(a1, ok, v);
          if (ok) begin ok1 = 1'b1; v1 = v; end
        end
        if (!ok2) begin
          model_lookup(a2, ok, v);
          if (ok) begin ok2 = 1'b1; v2 = v; end
        end
        step();
        total_cnt++;
        if (ok1 && ok2) begin
          got = 1'b1;
          if (out_valid !== 1'b1 || src1_data !== v1 || src2_data !== v2)
            $display("FAIL rand%0d_data: got vld=%b %h %h want 1 %h %h", t, out_valid, src1_data, src2_data, v1, v2);
          else pass_cnt++;
        end else begin
          if (out_valid !== 1'b0)
            $display("FAIL rand%0d_wait%0d: got vld=%b want 0", t, c, out_valid);
          else pass_cnt++;
        end
      end
      if (!got) begin
        total_cnt++;
        $display("FAIL rand%0d_timeout: got unresolved want resolved", t);
      end
      clear_bus();
      drain();
    end
    total_cnt++;
    if (stall_cycles !== (CNT_EN ? 32'(waits) : 32'd0))
      $display("FAIL rand_stall: got %0d want %0d", stall_cycles, CNT_EN ? waits : 0);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    src1_addr = '0; src2_addr = '0;
    src1_re = 1'b0; src2_re = 1'b0;
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    clear_bus();
    test_reset();
    test_no_hit();
    test_priority();
    test_load_use();
    test_zero_src();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
